// File: rtl/axi_ad7124_bram_arb.sv
// AD7124 capture buffer write scheduler: packs per-channel byte streams
// into 32-bit words and round-robins the single BRAM write port.
module axi_ad7124_bram_arb #(
    parameter int NUM_OF_BOARD = 6
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [NUM_OF_BOARD-1:0]   tc_sdi_valid,
    output logic [NUM_OF_BOARD-1:0]   tc_sdi_ready,
    input  logic [8*NUM_OF_BOARD-1:0] tc_sdi_data,
    input  logic [NUM_OF_BOARD-1:0]   rtd_sdi_valid,
    output logic [NUM_OF_BOARD-1:0]   rtd_sdi_ready,
    input  logic [8*NUM_OF_BOARD-1:0] rtd_sdi_data,
    input  logic                      ptr_clr,
    output logic [14*NUM_OF_BOARD-1:0] wr_ptr,
    output logic                      bram_clk,
    output logic                      bram_rst,
    output logic                      bram_en,
    output logic [3:0]                bram_we,
    output logic [12:0]               bram_addr,
    output logic [31:0]               bram_wrdata,
    input  logic [31:0]               bram_rddata
);

    localparam int C = 2 * NUM_OF_BOARD;

    logic [C-1:0] ch_valid;
    logic [7:0]   ch_data [C];
    logic [C-1:0] pending;
    logic [1:0]   byte_cnt [C];
    logic [31:0]  asm_q [C];
    logic [6:0]   ptr_q [C];
    logic [3:0]   last_grant;

    logic         gnt_vld;
    logic [C-1:0] gnt_oh;
    logic [3:0]   gnt_idx;
    logic [6:0]   gnt_ptr;
    logic [31:0]  gnt_word;
    int           idx;

    logic unused_rd;
    assign unused_rd = ^bram_rddata;

    assign bram_clk = aclk;
    assign bram_rst = areset;

    // Even channels carry TC, odd channels carry RTD of the same board
    for (genvar i = 0; i < NUM_OF_BOARD; i++) begin : g_map
        assign ch_valid[2*i]   = tc_sdi_valid[i];
        assign ch_valid[2*i+1] = rtd_sdi_valid[i];
        assign ch_data[2*i]    = tc_sdi_data[8*i +: 8];
        assign ch_data[2*i+1]  = rtd_sdi_data[8*i +: 8];
        assign tc_sdi_ready[i]  = ~pending[2*i];
        assign rtd_sdi_ready[i] = ~pending[2*i+1];
    end

    for (genvar k = 0; k < C; k++) begin : g_ptr
        assign wr_ptr[7*k +: 7] = ptr_q[k];
    end

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_oh   = '0;
        gnt_idx  = '0;
        gnt_ptr  = '0;
        gnt_word = '0;
        idx      = 0;
        for (int n = 1; n <= C; n++) begin
            idx = (int'(last_grant) + n) % C;
            if (!gnt_vld && pending[idx]) begin
                gnt_vld     = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = 4'(idx);
                gnt_ptr     = ptr_q[idx];
                gnt_word    = asm_q[idx];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            pending     <= '0;
            last_grant  <= 4'(C - 1);
            bram_en     <= 1'b0;
            bram_we     <= 4'h0;
            bram_addr   <= '0;
            bram_wrdata <= '0;
            for (int k = 0; k < C; k++) begin
                byte_cnt[k] <= '0;
                asm_q[k]    <= '0;
                ptr_q[k]    <= '0;
            end
        end else begin
            bram_en <= 1'b0;
            bram_we <= 4'h0;
            if (ptr_clr) begin
                // Soft clear wins over any byte or grant this cycle
                pending <= '0;
                for (int k = 0; k < C; k++) begin
                    byte_cnt[k] <= '0;
                    ptr_q[k]    <= '0;
                end
            end else begin
                for (int k = 0; k < C; k++) begin
                    if (ch_valid[k] && !pending[k]) begin
                        asm_q[k][8*byte_cnt[k] +: 8] <= ch_data[k];
                        byte_cnt[k] <= byte_cnt[k] + 2'd1;
                        if (byte_cnt[k] == 2'd3) begin
                            pending[k] <= 1'b1;
                        end
                    end
                    if (gnt_oh[k]) begin
                        pending[k] <= 1'b0;
                        ptr_q[k]   <= ptr_q[k] + 7'd1;
                    end
                end
                if (gnt_vld) begin
                    last_grant  <= gnt_idx;
                    bram_en     <= 1'b1;
                    bram_we     <= 4'hF;
                    bram_addr   <= {gnt_idx, gnt_ptr, 2'b00};
                    bram_wrdata <= gnt_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_ad7124_bram_arb.sv
// Scoreboard bench for axi_ad7124_bram_arb: expected BRAM writes are
// queued by stimulus and popped by a negedge monitor.
module tb_axi_ad7124_bram_arb;

    localparam int NB = 6;
    localparam int C  = 2 * NB;

    logic            aclk = 1'b0;
    logic            areset;
    logic [NB-1:0]   tc_sdi_valid, tc_sdi_ready;
    logic [8*NB-1:0] tc_sdi_data;
    logic [NB-1:0]   rtd_sdi_valid, rtd_sdi_ready;
    logic [8*NB-1:0] rtd_sdi_data;
    logic            ptr_clr;
    logic [7*C-1:0]  wr_ptr;
    logic            bram_clk, bram_rst, bram_en;
    logic [3:0]      bram_we;
    logic [12:0]     bram_addr;
    logic [31:0]     bram_wrdata;
    logic [31:0]     bram_rddata;

    axi_ad7124_bram_arb #(.NUM_OF_BOARD(NB)) dut (
        .aclk(aclk), .areset(areset),
        .tc_sdi_valid(tc_sdi_valid), .tc_sdi_ready(tc_sdi_ready),
        .tc_sdi_data(tc_sdi_data),
        .rtd_sdi_valid(rtd_sdi_valid), .rtd_sdi_ready(rtd_sdi_ready),
        .rtd_sdi_data(rtd_sdi_data),
        .ptr_clr(ptr_clr), .wr_ptr(wr_ptr),
        .bram_clk(bram_clk), .bram_rst(bram_rst), .bram_en(bram_en),
        .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [12:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   wr_cyc[$];
    int   exp_ptr [C];
    int   fair_cnt [C];
    int   last_wr [C];
    int   max_gap;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   fair_on = 0;
    bit   bp_on = 0;
    int   lo_cnt = 0;

    always @(negedge aclk) begin
        int ch;
        exp_t e;
        cyc++;
        if (bp_on && !rtd_sdi_ready[2]) lo_cnt++;
        if (!areset && bram_en) begin
            ch = int'(bram_addr[12:9]);
            wr_cyc.push_back(cyc);
            if (fair_on && ch < C) begin
                fair_cnt[ch]++;
                if (last_wr[ch] >= 0 && cyc - last_wr[ch] > max_gap)
                    max_gap = cyc - last_wr[ch];
                last_wr[ch] = cyc;
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h required=none",
                         bram_addr, bram_wrdata);
            end else begin
                e = exp_q.pop_front();
                if (bram_addr !== e.addr || bram_wrdata !== e.data ||
                    bram_we !== 4'hF) begin
                    errors++;
                    $display("FAIL write addr=%h data=%h we=%h required addr=%h data=%h we=f",
                             bram_addr, bram_wrdata, bram_we, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic rdy(int k);
        return (k % 2 == 0) ? tc_sdi_ready[k/2] : rtd_sdi_ready[k/2];
    endfunction

    task automatic drive(int k, logic v, logic [7:0] d);
        if (k % 2 == 0) begin
            tc_sdi_valid[k/2] = v;
            tc_sdi_data[8*(k/2) +: 8] = d;
        end else begin
            rtd_sdi_valid[k/2] = v;
            rtd_sdi_data[8*(k/2) +: 8] = d;
        end
    endtask

    task automatic send_byte(int k, logic [7:0] d);
        int n = 0;
        drive(k, 1'b1, d);
        while (!rdy(k) && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout ch=%0d ready=0 required=1", k);
        end
        @(negedge aclk);
        drive(k, 1'b0, 8'h00);
    endtask

    task automatic send_word(int k, logic [31:0] w);
        for (int j = 0; j < 4; j++) send_byte(k, w[8*j +: 8]);
    endtask

    task automatic push_word(int k, logic [31:0] w);
        exp_t e;
        e.addr = 13'(k * 512 + exp_ptr[k] * 4);
        e.data = w;
        exp_q.push_back(e);
        exp_ptr[k] = (exp_ptr[k] + 1) % 128;
    endtask

    task automatic clr_model();
        for (int k = 0; k < C; k++) exp_ptr[k] = 0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        clr_model();
    endtask

    task automatic drain(string name, int lim);
        int n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            @(negedge aclk);
            n++;
        end
        chk({name, "_drained"}, 128'(exp_q.size()), 128'd0);
        exp_q.delete();
        repeat (3) @(negedge aclk);
    endtask

    function automatic logic [31:0] fdat(int k, int w);
        return {8'(k), 8'(w), 8'hA5, 8'(k + w)};
    endfunction

    task automatic fair_drive(int k);
        for (int w = 0; w < 10; w++) send_word(k, fdat(k, w));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog sim_time_exceeded");
        $fatal(1);
    end

    initial begin
        int n0;
        areset = 1'b1;
        tc_sdi_valid = '0; tc_sdi_data = '0;
        rtd_sdi_valid = '0; rtd_sdi_data = '0;
        ptr_clr = 1'b0;
        bram_rddata = '0;
        clr_model();
        repeat (2) @(negedge aclk);
        chk("rst_tc_ready", 128'(tc_sdi_ready), 128'({NB{1'b1}}));
        chk("rst_rtd_ready", 128'(rtd_sdi_ready), 128'({NB{1'b1}}));
        chk("rst_bram_en", 128'(bram_en), 128'd0);
        chk("rst_bram_we", 128'(bram_we), 128'd0);
        chk("rst_bram_addr", 128'(bram_addr), 128'd0);
        chk("rst_bram_wrdata", 128'(bram_wrdata), 128'd0);
        chk("rst_wr_ptr", 128'(wr_ptr), 128'd0);
        areset = 1'b0;
        @(negedge aclk);

        // single word on channel 0
        push_word(0, 32'h44332211);
        send_word(0, 32'h44332211);
        chk("single_en_t1", 128'(bram_en), 128'd0);
        @(negedge aclk);
        chk("single_en_t2", 128'(bram_en), 128'd1);
        chk("single_wr_ptr0", 128'(wr_ptr[6:0]), 128'd1);
        drain("single", 10);

        // three channels complete together
        do_reset();
        wr_cyc.delete();
        push_word(0, 32'hA0A1A2A3);
        push_word(3, 32'hB0B1B2B3);
        push_word(11, 32'hC0C1C2C3);
        fork
            send_word(0, 32'hA0A1A2A3);
            send_word(3, 32'hB0B1B2B3);
            send_word(11, 32'hC0C1C2C3);
        join
        drain("rr", 10);
        chk("rr_nwrites", 128'(wr_cyc.size()), 128'd3);
        if (wr_cyc.size() == 3) begin
            chk("rr_consec1", 128'(wr_cyc[1] - wr_cyc[0]), 128'd1);
            chk("rr_consec2", 128'(wr_cyc[2] - wr_cyc[1]), 128'd1);
        end

        // 129 words into channel 5 with back-pressure and pointer wrap
        wr_cyc.delete();
        lo_cnt = 0;
        bp_on = 1;
        for (int w = 0; w < 129; w++) begin
            push_word(5, 32'h5000_0000 + 32'(w * 3));
            send_word(5, 32'h5000_0000 + 32'(w * 3));
        end
        drain("bp", 20);
        bp_on = 0;
        chk("bp_ready_low_cycles", 128'(lo_cnt), 128'd129);
        chk("bp_wr_ptr5", 128'(wr_ptr[35 +: 7]), 128'd1);
        chk("bp_nwrites", 128'(wr_cyc.size()), 128'd129);
        if (wr_cyc.size() == 129)
            chk("bp_rate", 128'(wr_cyc[128] - wr_cyc[0]), 128'd640);

        // all channels saturated
        do_reset();
        for (int k = 0; k < C; k++) begin
            fair_cnt[k] = 0;
            last_wr[k] = -1;
        end
        max_gap = 0;
        for (int w = 0; w < 10; w++)
            for (int k = 0; k < C; k++) push_word(k, fdat(k, w));
        fair_on = 1;
        for (int k = 0; k < C; k++) begin
            automatic int kk = k;
            fork
                fair_drive(kk);
            join_none
        end
        wait fork;
        drain("fair", 40);
        fair_on = 0;
        for (int k = 0; k < C; k++)
            chk($sformatf("fair_cnt_ch%0d", k), 128'(fair_cnt[k]), 128'd10);
        chk("fair_max_gap_le12", 128'(max_gap <= 12), 128'd1);

        // ptr_clr mid-word on channel 1
        send_byte(1, 8'hEE);
        send_byte(1, 8'hEF);
        ptr_clr = 1'b1;
        @(negedge aclk);
        ptr_clr = 1'b0;
        clr_model();
        n0 = wr_cyc.size();
        repeat (6) @(negedge aclk);
        chk("clr_no_write", 128'(wr_cyc.size()), 128'(n0));
        chk("clr_wr_ptr", 128'(wr_ptr), 128'd0);
        push_word(1, 32'h87654321);
        send_word(1, 32'h87654321);
        drain("clr_word", 10);

        // areset mid-word on channel 1
        send_byte(1, 8'h99);
        send_byte(1, 8'h98);
        n0 = wr_cyc.size();
        do_reset();
        repeat (4) @(negedge aclk);
        chk("rst_no_write", 128'(wr_cyc.size()), 128'(n0));
        push_word(1, 32'hCAFEF00D);
        send_word(1, 32'hCAFEF00D);
        drain("rst_word", 10);

        // ptr_clr together with 4th byte on channel 2
        send_byte(2, 8'h01);
        send_byte(2, 8'h02);
        send_byte(2, 8'h03);
        drive(2, 1'b1, 8'h04);
        ptr_clr = 1'b1;
        @(negedge aclk);
        ptr_clr = 1'b0;
        drive(2, 1'b0, 8'h00);
        clr_model();
        n0 = wr_cyc.size();
        chk("clr4_ready", 128'(tc_sdi_ready[1]), 128'd1);
        repeat (5) @(negedge aclk);
        chk("clr4_no_write", 128'(wr_cyc.size()), 128'(n0));
        push_word(2, 32'h0BADBEEF);
        send_word(2, 32'h0BADBEEF);
        drain("clr4_word", 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_ad7124_bram_arb.md
# axi_ad7124_bram_arb

Write scheduler for the AD7124 capture buffer. It collects the per-board thermocouple (TC) and RTD byte streams, packs each channel's bytes into 32-bit words, and arbitrates the single BRAM write port between all 2×NUM_OF_BOARD channels round-robin. Each channel owns a fixed 128-word ring region in BRAM, so software can read any channel's history through the other BRAM port.

## Interface
Parameters:
- NUM_OF_BOARD, 6, number of boards; legal range 1..8. Channel count is C = 2×NUM_OF_BOARD.

Ports:
- aclk  in  1  single clock for all logic.
- areset  in  1  synchronous, active-high reset.
- tc_sdi_valid  in  NUM_OF_BOARD  per-board TC byte valid.
- tc_sdi_ready  out  NUM_OF_BOARD  per-board TC byte ready.
- tc_sdi_data  in  8×NUM_OF_BOARD  TC bytes; board i is bits [8i+7:8i].
- rtd_sdi_valid / rtd_sdi_ready / rtd_sdi_data  same widths and meaning as the TC ports, for RTD.
- ptr_clr  in  1  single-cycle soft clear of all channel state.
- wr_ptr  out  7×C  next word slot per channel; channel k is bits [7k+6:7k].
- bram_clk  out  1  equal to aclk.
- bram_rst  out  1  equal to areset.
- bram_en  out  1  write strobe.
- bram_we  out  4  byte enables.
- bram_addr  out  13  byte address.
- bram_wrdata  out  32  write data.
- bram_rddata  in  32  unused; present for BRAM port compatibility.

## Operation
- Channel numbering: channel k = 2i carries board i TC; channel k = 2i+1 carries board i RTD.
- Per-channel state:
  - byte_cnt (2 bits)
  - 32-bit assembly register
  - pending flag
  - 7-bit wr_ptr
- Byte accept: a byte is taken on valid && ready. Ready = ~pending.
- Packing is little-endian: the first byte lands in [7:0] and the fourth in [31:24].
- On the 4th accepted byte, byte_cnt wraps to 0 and pending is set.
- Arbiter:
  - Eligible channels are those with pending = 1.
  - The winner is the first eligible channel searching upward from last_grant+1, modulo C.
  - At most one grant per cycle.
  - last_grant resets to C−1, so channel 0 has first priority.
- On a grant to channel k:
  - pending[k] clears.
  - wr_ptr[k] increments, wrapping 127→0.
  - The write registers load: bram_addr = {k[3:0], wr_ptr[k], 2'b00}, bram_wrdata = assembly word, bram_we = 4'hF, bram_en = 1.
- In cycles with no grant: bram_en = 0 and bram_we = 0. bram_addr and bram_wrdata hold their previous values.
- ptr_clr acts on the next edge:
  - Zeroes byte_cnt, pending and wr_ptr for every channel.
  - Discards any partial or pending words.
  - Suppresses any grant in the same cycle: bram_en = 0 on the next cycle.
  - last_grant is unchanged.
- Reset values:
  - All ready outputs = 1.
  - wr_ptr = 0.
  - bram_en = 0, bram_we = 0, bram_addr = 0, bram_wrdata = 0.
  - Internal: pending = 0, byte_cnt = 0.
- Reset mid-word discards partial bytes; no write is issued.
- No overflow condition exists: BRAM writes never stall, and back-pressure is applied only through ready.

## Timing
- Cycle t: 4th byte handshake. t+1: pending = 1, ready = 0, eligible for arbitration. Earliest bram_en = 1 is t+2.
- With one channel active, ready deasserts for exactly 1 cycle per word. Sustained rate is 4 bytes per 5 cycles.
- With n channels pending simultaneously, all are written within n consecutive cycles, in round-robin order.
- A channel granted at cycle g has ready = 1 at g+1 and may accept a new byte at g+1.
- A byte arriving on a channel while it is pending is not accepted, because ready = 0.
- wr_ptr updates on the same edge that registers the write, so the post-write value is visible together with bram_en.
- Simultaneous ptr_clr and 4th byte: the byte is discarded and pending stays 0.

## Test plan
- Reset check: hold areset 2 cycles → all ready = 1, bram_en = 0, wr_ptr all 0.
- Single word: channel 0 sends 0x11, 0x22, 0x33, 0x44 back-to-back.
  - bram_en = 1 exactly 2 cycles after the 4th byte.
  - addr = 0x0000, data = 0x44332211, we = 0xF.
  - wr_ptr[0] = 1.
- Round-robin: channels 0, 3 and 11 (NUM_OF_BOARD = 6) complete words in the same cycle.
  - Writes occur on three consecutive cycles in order 0, 3, 11.
  - Addresses 0x0000, 0x0600, 0x1600.
- Back-pressure and wrap: stream 129 words into RTD board 2 (channel 5).
  - Ready is low exactly 1 cycle per word.
  - Word 128 is written to 0x0A00; wr_ptr[5] ends at 1.
- Fairness: all 12 channels stream continuously → over 120 write cycles, each channel receives exactly 10 grants and no channel waits more than 12 cycles.
- ptr_clr / reset mid-word: send 2 bytes to channel 1, then pulse ptr_clr (then repeat with areset).
  - No write is issued.
  - The next 4 bytes form a full word at address 0x0200.
